// File: rtl/sms4_round_ctrl.sv
// Iterative SMS4 round sequencer: holds X0..X3, feeds one shared external T datapath
// per round and fetches round keys by index (ascending to encrypt, descending to decrypt).
module sms4_round_ctrl #(
    parameter int T_LAT   = 0,
    parameter int NROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dec,
    input  logic [0:127] din,
    output logic         ready,
    output logic [4:0]   rk_addr,
    input  logic [0:31]  rk,
    output logic [0:31]  t_arg,
    input  logic [0:31]  t_res,
    output logic         done,
    output logic [0:127] dout,
    output logic [1:0]   state_dbg
);

    // Handshake: start is accepted on a rising edge where ready=1 (ready is high only in IDLE);
    // done is a one-cycle strobe, and dout holds that result until the next done.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARG  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [2:0] WCNT_MAX = 3'(T_LAT);
    localparam logic [4:0] LAST     = 5'(NROUNDS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [0:31] x0, x1, x2, x3;
    logic [4:0]  round;
    logic [2:0]  wcnt;
    logic        dec_q;
    logic        upd;
    logic        last;

    assign upd       = (state == WAIT) && (wcnt == WCNT_MAX);
    assign last      = (round == LAST);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = ARG;
            end
            ARG:  state_nxt = WAIT;
            WAIT: if (upd) state_nxt = last ? IDLE : ARG;
            default: state_nxt = IDLE;
        endcase
    end

    // rk_addr is loaded on entry to ARG so the key store answers within the ARG cycle,
    // and it stays put through WAIT together with t_arg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0      <= '0;
            x1      <= '0;
            x2      <= '0;
            x3      <= '0;
            round   <= '0;
            wcnt    <= '0;
            dec_q   <= 1'b0;
            rk_addr <= '0;
            t_arg   <= '0;
            dout    <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x0      <= din[0:31];
                        x1      <= din[32:63];
                        x2      <= din[64:95];
                        x3      <= din[96:127];
                        dec_q   <= dec;
                        round   <= '0;
                        rk_addr <= dec ? 5'd31 : 5'd0;
                    end
                end
                ARG: begin
                    t_arg <= x1 ^ x2 ^ x3 ^ rk;
                    wcnt  <= '0;
                end
                WAIT: begin
                    if (upd) begin
                        x0 <= x1;
                        x1 <= x2;
                        x2 <= x3;
                        x3 <= x0 ^ t_res;
                        if (last) begin
                            dout <= {x0 ^ t_res, x3, x2, x1};
                            done <= 1'b1;
                        end else begin
                            round   <= round + 5'd1;
                            rk_addr <= dec_q ? (5'd30 - round) : (round + 5'd1);
                        end
                    end else begin
                        wcnt <= wcnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sms4_round_ctrl.sv
// Bench for sms4_round_ctrl: two instances (T_LAT=0 and T_LAT=3) with a bench-side
// SM4 key store and T function, checked against the standard SM4 test vector.
module tb_sms4_round_ctrl;

    localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

    localparam logic [7:0] SBOX [0:255] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic         start_a, dec_a, ready_a, done_a;
    logic [0:127] din_a, dout_a;
    logic [4:0]   rk_addr_a;
    logic [0:31]  rk_a, t_arg_a, t_res_a;
    logic [1:0]   state_dbg_a;

    logic         start_b, dec_b, ready_b, done_b;
    logic [0:127] din_b, dout_b;
    logic [4:0]   rk_addr_b;
    logic [0:31]  rk_b, t_arg_b, t_res_b;
    logic [1:0]   state_dbg_b;

    sms4_round_ctrl #(.T_LAT(0), .NROUNDS(32)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .dec(dec_a), .din(din_a),
        .ready(ready_a), .rk_addr(rk_addr_a), .rk(rk_a), .t_arg(t_arg_a),
        .t_res(t_res_a), .done(done_a), .dout(dout_a), .state_dbg(state_dbg_a)
    );

    sms4_round_ctrl #(.T_LAT(3), .NROUNDS(32)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .dec(dec_b), .din(din_b),
        .ready(ready_b), .rk_addr(rk_addr_b), .rk(rk_b), .t_arg(t_arg_b),
        .t_res(t_res_b), .done(done_b), .dout(dout_b), .state_dbg(state_dbg_b)
    );

    // ---------------- SM4 reference pieces ----------------
    logic [31:0] rk_tab [0:31];

    function automatic logic [31:0] rol(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [31:0] sbox_w(input logic [31:0] a);
        return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    endfunction

    function automatic logic [31:0] t_rnd(input logic [31:0] a);
        logic [31:0] b;
        b = sbox_w(a);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        b = sbox_w(a);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    task automatic expand_key(input logic [127:0] mk);
        logic [31:0] kk [0:35];
        logic [31:0] ck;
        kk[0] = mk[127:96] ^ 32'ha3b1bac6;
        kk[1] = mk[95:64]  ^ 32'h56aa3350;
        kk[2] = mk[63:32]  ^ 32'h677d9197;
        kk[3] = mk[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            ck = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
            kk[i+4] = kk[i] ^ t_key(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck);
            rk_tab[i] = kk[i+4];
        end
    endtask

    // key stores and T datapaths
    assign rk_a    = rk_tab[rk_addr_a];
    assign rk_b    = rk_tab[rk_addr_b];
    assign t_res_a = t_rnd(t_arg_a);

    // T_LAT=3 datapath: correct only once t_arg has been stable for 3 cycles, garbage otherwise
    logic [31:0] prev_b = '0;
    logic [31:0] garb_b = '0;
    int          age_b  = 0;
    always @(negedge clk) begin
        if (t_arg_b != prev_b) age_b <= 0;
        else if (age_b < 7)    age_b <= age_b + 1;
        prev_b <= t_arg_b;
        garb_b <= $urandom;
    end
    assign t_res_b = (age_b >= 3 && t_arg_b == prev_b) ? t_rnd(t_arg_b) : garb_b;

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q_a[$];
    logic [127:0] exp_q_b[$];
    int           cyc_q_a[$];
    int           cyc_q_b[$];
    logic [4:0]   addr_q_a[$];
    logic [31:0]  targ_q_b[$];
    int           checks = 0;
    int           passes = 0;
    int           done_cnt_a = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial begin : mon_a
        forever begin
            @(negedge clk);
            if (!rst_a && done_a) begin
                done_cnt_a++;
                if (exp_q_a.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done_a: done with dout %h at cycle %0d, none expected", dout_a, cyc);
                end else begin
                    chk("dout_a", dout_a, exp_q_a.pop_front());
                    chk("done_cycle_a", 128'(cyc), 128'(cyc_q_a.pop_front()));
                end
            end
            if (!rst_a && !ready_a && addr_q_a.size() > 0)
                chk("rk_addr_a", 128'(rk_addr_a), 128'(addr_q_a.pop_front()));
        end
    end

    initial begin : mon_b
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (!rst_b && done_b) begin
                if (exp_q_b.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done_b: done with dout %h at cycle %0d, none expected", dout_b, cyc);
                end else begin
                    chk("dout_b", dout_b, exp_q_b.pop_front());
                    chk("done_cycle_b", 128'(cyc), 128'(cyc_q_b.pop_front()));
                end
            end
            if (rst_b || ready_b) begin
                ph = 0;
            end else begin
                if (ph % 5 != 0 && targ_q_b.size() > 0) begin
                    chk("t_arg_hold_b", 128'(t_arg_b), 128'(targ_q_b[0]));
                    if (ph % 5 == 4) void'(targ_q_b.pop_front());
                end
                ph++;
            end
        end
    end

    // ---------------- drivers (called just after a falling edge) ----------------
    task automatic issue_a(input logic [127:0] blk, input bit d, input logic [127:0] expv);
        start_a = 1'b1;
        din_a   = blk;
        dec_a   = d;
        exp_q_a.push_back(expv);
        cyc_q_a.push_back(cyc + 1 + 64);
        for (int r = 0; r < 32; r++) begin
            addr_q_a.push_back(5'(d ? 31 - r : r));
            addr_q_a.push_back(5'(d ? 31 - r : r));
        end
        @(posedge clk);
        #1 start_a = 1'b0;
    endtask

    task automatic issue_b(input logic [127:0] blk, input bit d, input logic [127:0] expv);
        logic [31:0] x0, x1, x2, x3, a;
        {x0, x1, x2, x3} = blk;
        for (int r = 0; r < 32; r++) begin
            a = x1 ^ x2 ^ x3 ^ rk_tab[d ? 31 - r : r];
            targ_q_b.push_back(a);
            {x0, x1, x2, x3} = {x1, x2, x3, x0 ^ t_rnd(a)};
        end
        start_b = 1'b1;
        din_b   = blk;
        dec_b   = d;
        exp_q_b.push_back(expv);
        cyc_q_b.push_back(cyc + 1 + 160);
        @(posedge clk);
        #1 start_b = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n;
        n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_a) begin
            checks++;
            $display("FAIL done_timeout_a: no done within %0d cycles, required one", budget);
        end
    endtask

    task automatic wait_done_b(input int budget);
        int n;
        n = 0;
        while (!done_b && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_b) begin
            checks++;
            $display("FAIL done_timeout_b: no done within %0d cycles, required one", budget);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int dc;
        expand_key(PT);
        rst_a = 1'b1;  rst_b = 1'b1;
        start_a = 1'b0; dec_a = 1'b0; din_a = '0;
        start_b = 1'b0; dec_b = 1'b0; din_b = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 128'(ready_a), 128'(1));
        chk("reset_done", 128'(done_a), 128'(0));
        chk("reset_dout", dout_a, 128'(0));
        chk("reset_rk_addr", 128'(rk_addr_a), 128'(0));
        chk("reset_t_arg", 128'(t_arg_a), 128'(0));
        chk("reset_state", 128'(state_dbg_a), 128'(0));
        chk("reset_ready_b", 128'(ready_b), 128'(1));
        rst_a = 1'b0;  rst_b = 1'b0;
        @(negedge clk);

        // encryption, with a stray start mid-block that must be ignored
        issue_a(PT, 1'b0, CT);
        @(negedge clk);
        chk("rk_first_enc", 128'(rk_a), 128'(32'hf12186f9));
        repeat (20) @(negedge clk);
        start_a = 1'b1; din_a = 128'hdeadbeef00112233445566778899aabb; dec_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        @(negedge clk);
        wait_done_a(100);

        // decryption issued in the done cycle (no gap)
        chk("ready_in_done_cycle", 128'(ready_a), 128'(1));
        issue_a(CT, 1'b1, PT);
        @(negedge clk);
        chk("rk_first_dec", 128'(rk_a), 128'(32'h9124a012));
        wait_done_a(100);
        @(negedge clk);

        // async reset in round 17 abandons the block
        issue_a(PT, 1'b0, CT);
        repeat (35) @(negedge clk);
        chk("round17_rk_addr", 128'(rk_addr_a), 128'(17));
        #2 rst_a = 1'b1;
        exp_q_a.delete();
        cyc_q_a.delete();
        addr_q_a.delete();
        #1;
        chk("async_rst_ready", 128'(ready_a), 128'(1));
        chk("async_rst_done", 128'(done_a), 128'(0));
        chk("async_rst_dout", dout_a, 128'(0));
        chk("async_rst_rk_addr", 128'(rk_addr_a), 128'(0));
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        dc = done_cnt_a;
        repeat (80) @(negedge clk);
        chk("no_done_after_rst", 128'(done_cnt_a), 128'(dc));

        // fresh block after reset release
        issue_a(PT, 1'b0, CT);
        @(negedge clk);
        wait_done_a(100);
        @(negedge clk);

        // T_LAT=3 instance, same vector
        issue_b(PT, 1'b0, CT);
        @(negedge clk);
        wait_done_b(200);
        repeat (4) @(negedge clk);

        chk("pending_a", 128'(exp_q_a.size()), 128'(0));
        chk("pending_b", 128'(exp_q_b.size()), 128'(0));
        chk("pending_targ_b", 128'(targ_q_b.size()), 128'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sms4_round_ctrl.md
Name: sms4_round_ctrl

Overview:
- Iterative SMS4 round sequencer. Holds the 128-bit state X0..X3 and runs 32 rounds over one shared external T-function datapath (S-box layer plus L transform built from byte/bit rotators).
- Reads round keys from an external combinational round-key store by index. Supports encryption and decryption by key-index order only.
- Sits between the cipher top-level handshake and the shared round datapath.

Parameters:
- T_LAT, 0, pipeline latency of the external T datapath in cycles. 0 means combinational. Legal range is 0..7.
- NROUNDS, 32, number of rounds. Fixed for SMS4 and exposed only for bench shortening.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when ready=1
- dec  in  1  0=encrypt (rk index 0..31), 1=decrypt (rk index 31..0); latched with start
- din  in  [0:127]  input block; X0=din[0:31] .. X3=din[96:127]
- ready  out  1  high in IDLE
- rk_addr  out  5  round-key index for the current round
- rk  in  [0:31]  round key; valid combinationally for rk_addr in the same cycle
- t_arg  out  [0:31]  X1^X2^X3^rk, registered and held stable for the whole round
- t_res  in  [0:31]  T(t_arg), valid T_LAT cycles after t_arg changes
- done  out  1  one-cycle pulse when dout is updated
- dout  out  [0:127]  result (X35,X34,X33,X32), held until the next done

Behaviour:
- Reset (async, any state): state=IDLE, round=0, wcnt=0, X0..X3=0, t_arg=0, dout=0, done=0, rk_addr=0, latched dec=0. Reset mid-operation abandons the block; no done is produced.
- State machine has states IDLE, ARG, WAIT.
- IDLE:
  - ready=1.
  - On start=1: latch din into X0..X3, latch dec, round=0, go to ARG.
  - start is ignored in every other state.
- ARG (1 cycle):
  - rk_addr = dec ? 31-round : round.
  - Register t_arg <= X1^X2^X3^rk, wcnt=0, go to WAIT.
- WAIT:
  - When wcnt==T_LAT, the round updates: X0<=X1, X1<=X2, X2<=X3, X3<=X0^t_res.
  - Otherwise wcnt increments.
  - On update with round<NROUNDS-1: round++, go to ARG.
  - On update with round==NROUNDS-1: dout <= {X3_new, X2, X1, X0} as reversed words, i.e. dout[0:31]=new X3, dout[96:127]=old X1. done<=1 for one cycle, go to IDLE.
- rk_addr is held during WAIT. Both rk_addr and t_arg are stable from the ARG edge through the update edge.
- Round cost is T_LAT+2 cycles.
- Latency: start sampled at edge k gives done high in the cycle after edge k+NROUNDS*(T_LAT+2). For T_LAT=0, that is 64 cycles.
- start may be asserted in the same cycle done is high. ready is already 1 then, and the new block is accepted with no gap.
- round is a 5-bit counter and never wraps within a block. rk_addr stays within 0..31.
- Bit order is MSB-first [0:n]. Word Xi occupies bits 32i..32i+31.
- t_res is sampled only on the update edge. Values at other times are ignored.

Test Plan:
- Encryption vector, T_LAT=0:
  - Setup: bench models T and the key store for key 0123456789abcdeffedcba9876543210.
  - Stimulus: din=0123456789abcdeffedcba9876543210, dec=0.
  - Required: done pulse exactly 64 cycles after the start edge; dout=681edf34d206965e86b3e94f536e4246.
  - Required: rk_addr sequence 0,1,..,31, each value held 2 cycles; rk_addr=0 gives rk F12186F9.
- Decryption, T_LAT=0:
  - Stimulus: din=681edf34d206965e86b3e94f536e4246, dec=1.
  - Required: dout=0123456789abcdeffedcba9876543210; rk_addr sequence 31..0, first key 9124A012.
- T_LAT=3 rebuild:
  - Stimulus: same encryption vector with the bench's T delayed 3 cycles. Drive t_res with garbage during non-sampled cycles.
  - Required: same ciphertext; done 32*5=160 cycles after start.
  - Required: t_arg constant across each 5-cycle round.
- start while busy, then back-to-back:
  - Stimulus: pulse start with a different din mid-block.
  - Required: ignored, result unchanged.
  - Stimulus: assert start in the done cycle.
  - Required: second block accepted immediately (ready=1); second done 64 cycles later.
- Async reset at round 17:
  - Stimulus: assert rst at round 17.
  - Required: immediately ready=1, done=0, dout=0, rk_addr=0; no done pulse afterward.
  - Stimulus: new start after release.
  - Required: correct ciphertext.
